// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute/memory/writeback sequencer with memory timeout
module cpu_control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  Opcode,
    input  logic        BEQ,
    input  logic [12:0] newPC,
    input  logic        memDone,
    output logic [12:0] PC,
    output logic        read,
    output logic        write,
    output logic        instruction,
    output logic        instructionType,
    output logic [2:0]  ALU_Op,
    output logic        ALUSTART,
    output logic        writeFlag,
    output logic        memError
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, ERROR} state_t;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] OP_ADDI = 3'b100, OP_LD = 3'b101, OP_ST = 3'b110, OP_BEQ = 3'b111;
    state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [12:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        pc_d = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            FETCH, MEMORY: begin
                // memDone is honoured from the very first waiting cycle
                if (memDone) begin
                    state_d = state_q == FETCH ? DECODE : (op_q == OP_LD ? WRITEBACK : PCUPDATE);
                    cnt_d = '0;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                op_d = Opcode;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                state_d = (op_q == OP_LD || op_q == OP_ST) ? MEMORY : (op_q == OP_BEQ ? PCUPDATE : WRITEBACK);
                cnt_d = '0;
            end
            WRITEBACK: state_d = PCUPDATE;
            PCUPDATE: begin
                pc_d = (op_q == OP_BEQ && BEQ) ? newPC : pc_q + 13'd1;
                cnt_d = '0;
                state_d = FETCH;
            end
            ERROR: state_d = ERROR;
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            op_q <= '0;
            pc_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            pc_q <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign PC = pc_q;
    assign read = state_q == FETCH || (state_q == MEMORY && op_q == OP_LD);
    assign write = state_q == MEMORY && op_q == OP_ST;
    assign instruction = state_q == FETCH;
    assign ALUSTART = state_q == EXECUTE;
    assign writeFlag = state_q == WRITEBACK;
    assign memError = err_q;
    assign instructionType = !(op_q == OP_ADDI || op_q == OP_LD || op_q == OP_ST);
    assign ALU_Op = op_q[2] ? {2'b00, &op_q} : op_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: table-driven and randomized check of the control unit against a per-instruction trace model
module tb_cpu_control_unit;
    localparam int TO = 8;
    logic clk = 0, reset = 1, BEQ = 0, memDone = 0;
    logic [2:0] Opcode = 0;
    logic [12:0] newPC = 0;
    logic [12:0] PC;
    logic read, write, instruction, instructionType, ALUSTART, writeFlag, memError;
    logic [2:0] ALU_Op;
    int errors = 0, checks = 0;
    logic [12:0] model_pc = 0;

    cpu_control_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .BEQ(BEQ), .newPC(newPC), .memDone(memDone),
        .PC(PC), .read(read), .write(write), .instruction(instruction), .instructionType(instructionType),
        .ALU_Op(ALU_Op), .ALUSTART(ALUSTART), .writeFlag(writeFlag), .memError(memError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int lf;
        int lm;
        bit beq;
        logic [12:0] npc;
        logic [12:0] exp_pc;
        logic [2:0] exp_alu;
        bit exp_it;
    } vec_t;

    typedef struct {
        bit rd, wr, ins, as, wf, md, dec, pcu, wait_s, post_dec;
    } cyc_t;

    task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle behaviour is laid out phase by phase from the instruction's class
    task automatic run_instr(input vec_t v);
        cyc_t q[$];
        cyc_t c;
        bit is_mem = v.op == 3'd5 || v.op == 3'd6;
        for (int i = 0; i < v.lf; i++) begin
            c = '{default: 0};
            c.rd = 1; c.ins = 1; c.wait_s = 1; c.md = (i == v.lf - 1);
            q.push_back(c);
        end
        c = '{default: 0}; c.dec = 1; q.push_back(c);
        c = '{default: 0}; c.as = 1; c.post_dec = 1; q.push_back(c);
        if (is_mem)
            for (int i = 0; i < v.lm; i++) begin
                c = '{default: 0};
                c.rd = v.op == 3'd5; c.wr = v.op == 3'd6; c.wait_s = 1; c.post_dec = 1; c.md = (i == v.lm - 1);
                q.push_back(c);
            end
        if (v.op != 3'd6 && v.op != 3'd7) begin
            c = '{default: 0}; c.wf = 1; c.post_dec = 1; q.push_back(c);
        end
        c = '{default: 0}; c.pcu = 1; c.post_dec = 1; q.push_back(c);
        foreach (q[k]) begin
            c = q[k];
            chk("strobes", k, 32'({read, write, ALUSTART, writeFlag, memError}), 32'({c.rd, c.wr, c.as, c.wf, 1'b0}));
            chk("pc_hold", k, 32'(PC), 32'(model_pc));
            if (c.wait_s) chk("instruction", k, 32'(instruction), 32'(c.ins));
            if (c.post_dec) chk("aluop_itype", k, 32'({ALU_Op, instructionType}), 32'({v.exp_alu, v.exp_it}));
            memDone = c.wait_s ? c.md : 1'($urandom);
            Opcode = c.dec ? v.op : 3'($urandom);
            BEQ = c.pcu ? v.beq : 1'($urandom);
            newPC = c.pcu ? v.npc : 13'($urandom);
            step();
        end
        memDone = 0;
        chk("pc_next", q.size(), 32'(PC), 32'(v.exp_pc));
        chk("fetch_entry", q.size(), 32'({read, instruction}), 32'(2'b11));
        model_pc = v.exp_pc;
    endtask

    function automatic vec_t rand_vec(input logic [12:0] cur_pc);
        vec_t v;
        v.op = 3'($urandom);
        v.lf = int'($urandom_range(1, TO));
        v.lm = int'($urandom_range(1, TO));
        v.beq = 1'($urandom);
        v.npc = 13'($urandom);
        v.exp_pc = (v.op == 3'd7 && v.beq) ? v.npc : 13'((int'(cur_pc) + 1) % 8192);
        v.exp_alu = v.op <= 3'd3 ? v.op : (v.op == 3'd7 ? 3'd1 : 3'd0);
        v.exp_it = v.op <= 3'd3 || v.op == 3'd7;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{3'd0, 1, 1, 0, 13'd0,     13'd1,     3'd0, 1};
        tbl[1]  = '{3'd5, 1, 3, 0, 13'd0,     13'd2,     3'd0, 0};
        tbl[2]  = '{3'd6, 2, 3, 1, 13'd77,    13'd3,     3'd0, 0};
        tbl[3]  = '{3'd7, 1, 1, 1, 13'h0A0,   13'h0A0,   3'd1, 1};
        tbl[4]  = '{3'd7, 2, 1, 0, 13'h155,   13'h0A1,   3'd1, 1};
        tbl[5]  = '{3'd1, TO, 1, 1, 13'd5,    13'h0A2,   3'd1, 1};
        tbl[6]  = '{3'd2, 3, 1, 0, 13'd0,     13'h0A3,   3'd2, 1};
        tbl[7]  = '{3'd3, 1, 1, 1, 13'd9,     13'h0A4,   3'd3, 1};
        tbl[8]  = '{3'd5, 1, TO, 1, 13'd4,    13'h0A5,   3'd0, 0};
        tbl[9]  = '{3'd7, 1, 1, 1, 13'd8191,  13'd8191,  3'd1, 1};
        tbl[10] = '{3'd4, 1, 1, 1, 13'd42,    13'd0,     3'd0, 0};

        repeat (2) step();
        chk("reset_state", 0, 32'({read, write, instruction, ALUSTART, writeFlag, memError, PC}), 32'({6'b101000, 13'd0}));
        reset = 0;
        foreach (tbl[i]) run_instr(tbl[i]);
        for (int i = 0; i < 200; i++) run_instr(rand_vec(model_pc));

        // Timeout in FETCH: still fetching on the last allowed cycle, then ERROR
        memDone = 0;
        repeat (TO - 1) step();
        chk("timeout_last_wait", 0, 32'({read, memError}), 32'(2'b10));
        step();
        chk("error_state", 0, 32'({read, write, ALUSTART, writeFlag, memError, PC}), 32'({5'b00001, model_pc}));
        memDone = 1;
        repeat (3) step();
        chk("error_sticky", 0, 32'({read, write, ALUSTART, writeFlag, memError, PC}), 32'({5'b00001, model_pc}));
        memDone = 0;
        reset = 1;
        step();
        chk("error_reset", 0, 32'({read, instruction, memError, PC}), 32'({3'b110, 13'd0}));
        reset = 0;
        model_pc = 0;
        run_instr(tbl[0]);

        // Reset in the middle of a store's memory phase
        memDone = 1;
        step();
        memDone = 0;
        Opcode = 3'd6;
        step();
        Opcode = 3'd0;
        step();
        chk("st_memory", 0, 32'({read, write, instruction}), 32'(3'b010));
        reset = 1;
        step();
        chk("st_reset", 0, 32'({read, write, instruction, PC}), 32'({3'b101, 13'd0}));
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
